// File: rtl/left_shift_seq.sv
// left_shift_seq: multi-cycle left shifter with one log2 stage per clock and a start/ready handshake.
// Define LEFT_SHIFT_ROTATE_EN to add ctrl_rotate, which selects rotate-left.
module left_shift_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ctrl_shift,
`ifdef LEFT_SHIFT_ROTATE_EN
    input  logic               ctrl_rotate,
`endif
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] amt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);
    localparam int IW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d, result_q, result_d, stage_out;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic [IW-1:0]      idx_q, idx_d;
    int                 k;
`ifdef LEFT_SHIFT_ROTATE_EN
    logic               rot_q, rot_d;
`endif
    always_comb begin
        k = 32'd1 << idx_q;
`ifdef LEFT_SHIFT_ROTATE_EN
        stage_out = !amt_q[idx_q] ? work_q :
                    rot_q ? (work_q << k) | (work_q >> (WIDTH - k)) : work_q << k;
        rot_d = rot_q;
`else
        stage_out = amt_q[idx_q] ? work_q << k : work_q;
`endif
        state_d  = state_q;
        work_d   = work_q;
        amt_d    = amt_q;
        idx_d    = idx_q;
        result_d = result_q;
        // A new operand is accepted from IDLE or straight out of DONE (back-to-back)
        if (ctrl_shift && state_q != SHIFT) begin
            state_d = SHIFT;
            work_d  = data_in;
            amt_d   = amt;
            idx_d   = IW'(SHAMT_W - 1);
`ifdef LEFT_SHIFT_ROTATE_EN
            rot_d   = ctrl_rotate;
`endif
        end else if (state_q == SHIFT) begin
            work_d = stage_out;
            if (idx_q == '0) begin
                state_d  = DONE;
                result_d = stage_out;
            end else begin
                idx_d = idx_q - IW'(1);
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            amt_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
`ifdef LEFT_SHIFT_ROTATE_EN
            rot_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            amt_q    <= amt_d;
            idx_q    <= idx_d;
            result_q <= result_d;
`ifdef LEFT_SHIFT_ROTATE_EN
            rot_q    <= rot_d;
`endif
        end
    end
    assign data_result    = result_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == SHIFT);
endmodule
